// File: rtl/bcd_max_tracker.sv
// Running maximum of a stream of packed BCD samples.
// Each accepted sample is compared against the stored maximum one digit per
// clock, most significant digit first, stopping at the first differing digit.
// Samples containing a nibble above 9 are rejected with a one-cycle pulse.
//
// Handshake: a sample transfers on a rising edge where in_valid_i and
// in_ready_o are both high; in_bcd_i is captured on that edge. in_ready_o is
// high only while the controller is idle and no soft clear is requested, so
// the source may hold in_valid_i high across busy cycles without the sample
// being taken twice.
module bcd_max_tracker #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [4*DIGITS-1:0]   in_bcd_i,
  output logic [4*DIGITS-1:0]   max_bcd_o,
  output logic                  max_valid_o,
  output logic                  new_max_o,
  output logic                  bad_digit_o,
  output logic [CNT_W-1:0]      sample_cnt_o,
  output logic                  state_o
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_MSD = IDX_W'(DIGITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       max_q, max_d;
  logic [W-1:0]       cand_q, cand_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               max_valid_q, max_valid_d;
  logic               new_max_q, new_max_d;
  logic               bad_digit_q, bad_digit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Single-digit A>=B rule shared with the combinational BCD comparator;
  // greater-than and equality are both derived from it.
  function automatic logic digit_ge(input logic [3:0] a, input logic [3:0] b);
    return a >= b;
  endfunction

  logic       in_bad;
  logic [3:0] cand_digit;
  logic [3:0] max_digit;
  logic       digit_gt;
  logic       digit_eq;
  logic       transfer;

  // Flag any nibble of the offered sample that is not a decimal digit.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (in_bcd_i[i*4 +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // Select the digit pair currently under comparison.
  always_comb begin
    cand_digit = 4'd0;
    max_digit  = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cand_digit = cand_q[i*4 +: 4];
        max_digit  = max_q[i*4 +: 4];
      end
    end
    digit_gt = digit_ge(cand_digit, max_digit) && !digit_ge(max_digit, cand_digit);
    digit_eq = digit_ge(cand_digit, max_digit) &&  digit_ge(max_digit, cand_digit);
  end

  assign in_ready_o = (state_q == IDLE) && !clear_i;
  assign transfer   = in_valid_i && in_ready_o;

  // Next-state and register-update logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    cand_d      = cand_q;
    idx_d       = idx_q;
    max_valid_d = max_valid_q;
    cnt_d       = cnt_q;
    new_max_d   = 1'b0;
    bad_digit_d = 1'b0;

    if (clear_i) begin
      // Soft clear forgets the maximum and abandons any compare; the
      // accepted-sample count is deliberately kept.
      state_d     = IDLE;
      max_d       = '0;
      max_valid_d = 1'b0;
      idx_d       = IDX_MSD;
    end else begin
      case (state_q)
        IDLE: begin
          if (transfer) begin
            if (in_bad) begin
              bad_digit_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              if (!max_valid_q) begin
                // First sample after reset/clear becomes the maximum directly.
                max_d       = in_bcd_i;
                max_valid_d = 1'b1;
                new_max_d   = 1'b1;
              end else begin
                cand_d  = in_bcd_i;
                idx_d   = IDX_MSD;
                state_d = CMP;
              end
            end
          end
        end
        CMP: begin
          if (digit_gt) begin
            max_d     = cand_q;
            new_max_d = 1'b1;
            state_d   = IDLE;
          end else if (!digit_eq) begin
            state_d = IDLE;
          end else if (idx_q == '0) begin
            // Full tie: stored maximum already equals the candidate.
            state_d = IDLE;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      max_q       <= '0;
      cand_q      <= '0;
      idx_q       <= IDX_MSD;
      max_valid_q <= 1'b0;
      new_max_q   <= 1'b0;
      bad_digit_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      cand_q      <= cand_d;
      idx_q       <= idx_d;
      max_valid_q <= max_valid_d;
      new_max_q   <= new_max_d;
      bad_digit_q <= bad_digit_d;
      cnt_q       <= cnt_d;
    end
  end

  assign max_bcd_o    = max_q;
  assign max_valid_o  = max_valid_q;
  assign new_max_o    = new_max_q;
  assign bad_digit_o  = bad_digit_q;
  assign sample_cnt_o = cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_bcd_max_tracker.sv
// Bench for bcd_max_tracker: directed scenarios followed by random traffic,
// checked against a decimal-arithmetic model of the running maximum.
module tb_bcd_max_tracker;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int TOP    = 1000;  // weight of the most significant digit

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         clear;
  logic         in_valid;
  logic [W-1:0] in_bcd;

  logic         in_ready_o, max_valid_o, new_max_o, bad_digit_o, state_o;
  logic [W-1:0] max_bcd_o;
  logic [7:0]   sample_cnt_o;

  logic         ready2, valid2, new2, bad2, state2;
  logic [W-1:0] max2;
  logic [1:0]   cnt2;

  bcd_max_tracker #(.DIGITS(DIGITS), .CNT_W(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(in_ready_o), .in_bcd_i(in_bcd), .max_bcd_o(max_bcd_o),
    .max_valid_o(max_valid_o), .new_max_o(new_max_o), .bad_digit_o(bad_digit_o),
    .sample_cnt_o(sample_cnt_o), .state_o(state_o)
  );

  // Narrow-counter instance driven identically, used for wrap checks.
  bcd_max_tracker #(.DIGITS(DIGITS), .CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(ready2), .in_bcd_i(in_bcd), .max_bcd_o(max2),
    .max_valid_o(valid2), .new_max_o(new2), .bad_digit_o(bad2),
    .sample_cnt_o(cnt2), .state_o(state2)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  logic [W-1:0] m_max;
  logic         m_valid;
  int           m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      v[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return v;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit b = 0;
    for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) b = 1;
    return b;
  endfunction

  // Number of digit steps needed to decide: position of first differing digit.
  function automatic int decide_k(input int a, input int b);
    int p = TOP;
    for (int k = 1; k <= DIGITS; k++) begin
      if ((a / p) % 10 != (b / p) % 10) return k;
      p = p / 10;
    end
    return DIGITS;
  endfunction

  // Every new_max pulse must match the next expected new maximum.
  always @(negedge clk) begin
    if (!rst) begin
      chk("pulse_exclusive", {31'd0, new_max_o & bad_digit_o}, 32'd0);
      if (new_max_o) begin
        if (exp_q.size() == 0) begin
          chk("newmax_unexpected", {31'd0, new_max_o}, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("newmax_value", 32'(max_bcd_o), 32'(mon_exp));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_state(input string tag);
    chk({tag, "_max"},   32'(max_bcd_o),    32'(m_max));
    chk({tag, "_valid"}, 32'(max_valid_o),  32'(m_valid));
    chk({tag, "_cnt"},   32'(sample_cnt_o), 32'(m_cnt % 256));
    chk({tag, "_cnt2"},  32'(cnt2),         32'(m_cnt % 4));
    chk({tag, "_ready"}, 32'(in_ready_o),   32'd1);
  endtask

  task automatic send(input logic [W-1:0] v, input bit keep);
    int n;
    int k;
    bit gt;
    @(negedge clk);
    in_valid = 1'b1;
    in_bcd   = v;
    n = 0;
    while (!in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(in_ready_o), 32'd1);
    if (!in_ready_o) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!keep) begin
      in_valid = 1'b0;
      in_bcd   = W'($urandom);
    end
    if (has_bad(v)) begin
      chk("bad_pulse", 32'(bad_digit_o), 32'd1);
      chk("bad_newmax", 32'(new_max_o), 32'd0);
      check_state("bad");
    end else if (!m_valid) begin
      m_cnt++;
      m_max   = v;
      m_valid = 1'b1;
      exp_q.push_back(v);
      chk("load_pulse", 32'(new_max_o), 32'd1);
      chk("load_bad", 32'(bad_digit_o), 32'd0);
      check_state("load");
    end else begin
      m_cnt++;
      k  = decide_k(bcd2int(v), bcd2int(m_max));
      gt = bcd2int(v) > bcd2int(m_max);
      for (int j = 0; j < k; j++) begin
        chk("cmp_busy", 32'(in_ready_o), 32'd0);
        chk("cmp_nopulse", 32'(new_max_o), 32'd0);
        @(posedge clk); #1;
      end
      if (gt) begin
        m_max = v;
        exp_q.push_back(v);
      end
      chk("cmp_pulse", 32'(new_max_o), 32'(gt));
      check_state("cmp");
    end
  endtask

  // Accept a sample that needs a compare and return while it is in flight.
  task automatic start_cmp(input logic [W-1:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_bcd   = v;
    chk("start_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_cnt++;
    chk("start_busy", 32'(in_ready_o), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    m_max = '0; m_valid = 1'b0; m_cnt = 0;
    chk({tag, "_newmax"}, 32'(new_max_o),   32'd0);
    chk({tag, "_bad"},    32'(bad_digit_o), 32'd0);
    check_state(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;          // offered during clear: must not be taken
    in_bcd   = 16'h0500;
    #1;
    chk({tag, "_ready_low"}, 32'(in_ready_o), 32'd0);
    @(posedge clk); #1;
    m_max = '0; m_valid = 1'b0;
    chk({tag, "_newmax"}, 32'(new_max_o), 32'd0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_state(tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] v;
    int r;
    int n;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bcd = '0;
    m_max = '0; m_valid = 1'b0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_newmax", 32'(new_max_o), 32'd0);
    chk("rst_bad", 32'(bad_digit_o), 32'd0);
    check_state("rst");
    @(negedge clk);
    rst = 1'b0;

    // First load, MSD decisions (update and reject).
    send(16'h1234, 0);
    send(16'h2000, 0);
    send(16'h0999, 0);

    // Full-length compare, then a full tie.
    do_reset("rst2");
    send(16'h1234, 0);
    send(16'h1235, 0);
    send(16'h1235, 0);

    // Malformed sample.
    send(16'h12A4, 0);
    chk("bad_cnt", 32'(sample_cnt_o), 32'd3);

    // Clear during a compare, then direct reload.
    do_reset("rst3");
    send(16'h1234, 0);
    start_cmp(16'h1299);
    do_clear("clr");
    send(16'h0001, 0);

    // Reset during a compare.
    send(16'h0002, 0);
    start_cmp(16'h0003);
    do_reset("rst_mid");

    // Back-to-back offers; narrow counter wraps after 4.
    send(16'h0500, 1);
    send(16'h0400, 1);
    send(16'h0501, 1);
    send(16'h0501, 1);
    send(16'h9999, 1);
    in_valid = 1'b0;
    chk("wrap_cnt2", 32'(cnt2), 32'd1);
    chk("wrap_cnt8", 32'(sample_cnt_o), 32'd5);

    // Random traffic, biased toward near-equal values for long compares.
    for (int it = 0; it < 320; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        v = int2bcd($urandom_range(0, 9999));
        n = $urandom_range(0, DIGITS - 1);
        v[n*4 +: 4] = 4'($urandom_range(10, 15));
      end else if (r < 6 && m_valid) begin
        n = bcd2int(m_max) + int'($urandom_range(0, 40)) - 20;
        if (n < 0) n = 0;
        if (n > 9999) n = 9999;
        v = int2bcd(n);
      end else begin
        v = int2bcd($urandom_range(0, 9999));
      end
      if (r == 9 && it % 7 == 0) do_clear("rclr");
      send(v, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
